// File: rtl/lfsr_seq_ctrl.sv
// rtl/lfsr_seq_ctrl.sv - seed/shift job sequencer driving a 32-bit lfsr over request/response handshakes
// Optional WAIT timeout abort is built only when LFSR_CTRL_TIMEOUT_EN is defined.
module lfsr_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
`ifdef LFSR_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_seed,
  input  logic [CNT_W-1:0]  req_count,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              lfsr_set,
  output logic              lfsr_shift,
  output logic [DATA_W-1:0] lfsr_seed,
  input  logic [DATA_W-1:0] lfsr_state,
  input  logic              lfsr_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_WAIT, S_CAPTURE, S_RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;

`ifdef LFSR_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      lfsr_seed <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
`ifdef LFSR_CTRL_TIMEOUT_EN
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lfsr_seed <= req_seed;
            remaining <= req_count;
            state     <= S_LOAD;
          end
        end
        S_LOAD: state <= (remaining == '0) ? S_CAPTURE : S_SHIFT;
        S_SHIFT: begin
          // SHIFT is only entered with remaining > 0, so this cannot wrap
          remaining <= remaining - 1'b1;
          state     <= S_WAIT;
`ifdef LFSR_CTRL_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
        end
        S_WAIT: begin
          if (lfsr_done) begin
            state <= (remaining == '0) ? S_CAPTURE : S_SHIFT;
          end
`ifdef LFSR_CTRL_TIMEOUT_EN
          else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            state     <= S_CAPTURE;
            rsp_err   <= 1'b1;
            remaining <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_CAPTURE: begin
          rsp_data  <= lfsr_state;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifdef LFSR_CTRL_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are pure state decodes, forced low while reset is asserted
  assign req_ready  = !rst && (state == S_IDLE);
  assign busy       = !rst && (state != S_IDLE);
  assign lfsr_set   = !rst && (state == S_LOAD);
  assign lfsr_shift = !rst && (state == S_SHIFT);

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb/tb_lfsr_seq_ctrl.sv - randomized self-checking bench for lfsr_seq_ctrl with a behavioural lfsr
module tb_lfsr_seq_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_seed = '0;
  logic [7:0]  req_count = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        lfsr_set;
  logic        lfsr_shift;
  logic [31:0] lfsr_seed;
  logic [31:0] lfsr_state;
  logic        lfsr_done = 1'b0;

  int errors = 0;
  int checks = 0;

  lfsr_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_seed(req_seed), .req_count(req_count),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .lfsr_set(lfsr_set), .lfsr_shift(lfsr_shift), .lfsr_seed(lfsr_seed),
    .lfsr_state(lfsr_state), .lfsr_done(lfsr_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [31:0] lfsr_after(input logic [31:0] seed, input int n);
    logic [31:0] s = seed;
    for (int i = 0; i < n; i++) s = lfsr_step(s);
    return s;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural lfsr stand-in: done returns done_delay cycles after each shift pulse
  logic [31:0] lfsr_q = '0;
  int          done_delay = 1;
  bit          no_done = 1'b0;
  bit          stray = 1'b0;
  int          pend = 0;
  assign lfsr_state = lfsr_q;

  always @(posedge clk) begin
    lfsr_done <= stray;
    if (rst) pend <= 0;
    else if (lfsr_shift && !no_done) begin
      if (done_delay <= 1) lfsr_done <= 1'b1;
      else pend <= done_delay - 1;
    end else if (pend == 1) begin
      lfsr_done <= 1'b1;
      pend <= 0;
    end else if (pend > 1) pend <= pend - 1;
    if (lfsr_set) lfsr_q <= lfsr_seed;
    else if (lfsr_shift) lfsr_q <= lfsr_step(lfsr_q);
  end

  int cyc = 0;
  int set_cnt = 0;
  int shift_cnt = 0;
  int both_hi = 0;
  int shift_cyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (lfsr_set) set_cnt <= set_cnt + 1;
    if (lfsr_shift) begin
      shift_cnt <= shift_cnt + 1;
      shift_cyc.push_back(cyc);
    end
    if (lfsr_set && lfsr_shift) both_hi <= both_hi + 1;
  end

  task automatic run_job(input logic [31:0] seed, input int n, input int d, input int hold,
                         input bit expect_err);
    int s0, h0, q0, acc, k, nsh, exp_lat;
    logic [31:0] exp;
    bit ok;
    nsh     = expect_err ? 1 : n;
    exp     = lfsr_after(seed, nsh);
    exp_lat = expect_err ? 3 + TIMEOUT : 2 + n * (d + 1);
    done_delay = d;
    @(negedge clk);
    req_valid = 1'b1;
    req_seed  = seed;
    req_count = 8'(n);
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("accept_ready", 32'(req_ready), 1);
    s0 = set_cnt; h0 = shift_cnt; q0 = shift_cyc.size(); acc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_eq("rsp_valid_seen", 32'(rsp_valid), 1);
    check_eq("latency", cyc - acc, exp_lat);
    check_eq("rsp_data", rsp_data, exp);
    check_eq("rsp_err", 32'(rsp_err), 32'(expect_err));
    check_eq("set_pulses", set_cnt - s0, 1);
    check_eq("shift_pulses", shift_cnt - h0, nsh);
    check_eq("seed_held", lfsr_seed, seed);
    ok = 1'b1;
    for (int i = q0 + 1; i < shift_cyc.size(); i++)
      if (shift_cyc[i] - shift_cyc[i-1] != d + 1) ok = 1'b0;
    check_eq("shift_spacing", 32'(ok), 1);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_seed  = ~seed;
      stray     = (i == 2);
      @(negedge clk);
      check_eq("hold_valid", 32'(rsp_valid), 1);
      check_eq("hold_data", rsp_data, exp);
      check_eq("hold_err", 32'(rsp_err), 32'(expect_err));
      check_eq("hold_no_accept", 32'(req_ready), 0);
    end
    stray     = 1'b0;
    req_valid = 1'b0;
    req_seed  = seed;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_taken_valid", 32'(rsp_valid), 0);
    check_eq("rsp_taken_err", 32'(rsp_err), 0);
    check_eq("back_to_idle", 32'(req_ready), 1);
    check_eq("seed_after_hold", lfsr_seed, seed);
  endtask

  initial begin
    int k;
    bit seen;
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_set_shift", {30'b0, lfsr_set, lfsr_shift}, 0);
    check_eq("rst_rsp", {30'b0, rsp_valid, rsp_err}, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_seed", lfsr_seed, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", 32'(req_ready), 1);

    run_job(32'h8020_0003, 0, 1, 0, 1'b0);
    run_job(32'h8020_0003, 4, 1, 0, 1'b0);
    run_job($urandom, 2, 1, 20, 1'b0);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    check_eq("stray_idle_busy", 32'(busy), 0);
    run_job($urandom, 3, 5, 4, 1'b0);
    run_job($urandom, 255, 1, 1, 1'b0);
    for (int j = 0; j < 6; j++)
      run_job($urandom, $urandom_range(0, 12), $urandom_range(1, 4), $urandom_range(0, 5), 1'b0);

    // Reset in the middle of a job drops it without a response
    done_delay = 1;
    @(negedge clk);
    req_valid = 1'b1;
    req_seed  = $urandom;
    req_count = 8'd10;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!lfsr_shift && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("mid_shift_seen", 32'(lfsr_shift), 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_outputs", {28'b0, req_ready, busy, lfsr_set, lfsr_shift}, 0);
    check_eq("mid_rst_rsp", {30'b0, rsp_valid, rsp_err}, 0);
    check_eq("mid_rst_seed", lfsr_seed, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(req_ready), 1);
    check_eq("post_rst_busy", 32'(busy), 0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1'b1;
    end
    check_eq("dropped_job", 32'(seen), 0);

`ifdef LFSR_CTRL_TIMEOUT_EN
    no_done = 1'b1;
    run_job($urandom, 3, 1, 2, 1'b1);
    no_done = 1'b0;
    run_job($urandom, 3, 1, 0, 1'b0);
`endif

    run_job($urandom, $urandom_range(1, 8), 2, 1, 1'b0);
    check_eq("set_shift_overlap", both_hi, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
